// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/VALID fetch FSM with branch/jump next-pc selection.
// Optional fetch timeout compiled in with `define FETCH_TIMEOUT_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        take_branch,
    input  logic        take_jump,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        imem_req_r;
    logic        instr_valid_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;

    // Jump keeps the 256 MB region of the sequential address.
    function automatic logic [31:0] jump_target(input logic [31:0] seq_pc, input logic [31:0] ins);
        jump_target = {seq_pc[31:28], ins[25:0], 2'b00};
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] seq_pc, input logic [31:0] ins);
        branch_target = seq_pc + {{14{ins[15]}}, ins[15:0], 2'b00};
    endfunction

    assign pc_plus4_s = pc_r + 32'd4;

    // Next-pc selection: jump beats branch beats sequential.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (take_jump) begin
            next_pc_s = jump_target(pc_plus4_s, instr_r);
        end else if (take_branch) begin
            next_pc_s = branch_target(pc_plus4_s, instr_r);
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt_r;
    logic       fetch_error_r;
`endif

    // Fetch FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= 32'h0000_0000;
            instr_r       <= 32'h0000_0000;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_r     <= 4'd0;
            fetch_error_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_REQ;
                    imem_req_r <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_r  <= 4'd0;
`endif
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr_r       <= imem_rdata;
                        state_r       <= ST_VALID;
                        imem_req_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Sixteenth unacknowledged cycle: deliver a NOP and flag the error.
                    else if (tmo_cnt_r == 4'd15) begin
                        instr_r       <= 32'h0000_0000;
                        state_r       <= ST_VALID;
                        imem_req_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                        fetch_error_r <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 4'd1;
                    end
`else
                    else begin
                        state_r <= ST_REQ;
                    end
`endif
                end
                ST_VALID: begin
                    if (!stall) begin
                        pc_r          <= {next_pc_s[31:2], 2'b00};
                        state_r       <= ST_REQ;
                        imem_req_r    <= 1'b1;
                        instr_valid_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt_r     <= 4'd0;
`endif
                    end else begin
                        state_r <= ST_VALID;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = pc_r;
    assign imem_req    = imem_req_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[31:26];
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign instr_valid = instr_valid_r;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_error = fetch_error_r;
`else
    assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (timeout checks follow FETCH_TIMEOUT_EN).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall;
    logic        take_branch;
    logic        take_jump;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_error;

    int          n_pass  = 0;
    int          n_total = 0;
    bit          seen;
    logic [31:0] addr;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .stall(stall), .take_branch(take_branch), .take_jump(take_jump),
        .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fetch_error(fetch_error)
    );

    // Wait (bounded) for a request, answer it with rdata; returns with the DUT in VALID.
    task automatic fetch(input logic [31:0] rdata, output bit got, output logic [31:0] req_addr);
        got = 1'b0;
        req_addr = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            req_addr   = imem_addr;
            imem_ack   = 1'b1;
            imem_rdata = rdata;
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 32'hA5A5_5A5A;
        end
    endtask

    // Release stall for one cycle with the given redirect inputs.
    task automatic advance(input logic j, input logic b);
        stall       = 1'b0;
        take_jump   = j;
        take_branch = b;
        @(negedge clk);
        stall       = 1'b1;
        take_jump   = 1'b0;
        take_branch = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        stall = 1'b1; take_jump = 1'b0; take_branch = 1'b0;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        n_total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want %h", instr, 32'h0); else n_pass++;
        n_total++; if (opcode !== 6'h0) $display("FAIL reset_opcode: got %h want %h", opcode, 6'h0); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
        n_total++; if (fetch_error !== 1'b0) $display("FAIL reset_err: got %b want 0", fetch_error); else n_pass++;
    endtask

    task automatic test_basic;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req: req %b addr %h want 1 %h", imem_req, imem_addr, 32'h0); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL req_bubble: got %b want 0", instr_valid); else n_pass++;
        fetch(32'h8C01_0004, seen, addr);
        n_total++; if (instr_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", instr_valid); else n_pass++;
        n_total++; if (opcode !== 6'b100011) $display("FAIL basic_opcode: got %b want %b", opcode, 6'b100011); else n_pass++;
        n_total++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) $display("FAIL basic_pc: got %h/%h want 0/4", pc, pc_plus4); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL valid_req: got %b want 0", imem_req); else n_pass++;
        advance(1'b0, 1'b0);
        fetch(32'h0000_0000, seen, addr);
        n_total++; if (!seen || addr !== 32'h4) $display("FAIL seq_addr: seen %b addr %h want %h", seen, addr, 32'h4); else n_pass++;
        n_total++; if (pc !== 32'h4 || instr_valid !== 1'b1) $display("FAIL seq_pc: got %h valid %b want %h 1", pc, instr_valid, 32'h4); else n_pass++;
    endtask

    task automatic test_stall;
        advance(1'b0, 1'b0);
        fetch(32'h0800_0040, seen, addr);
        for (int i = 0; i < 5; i++) begin
            take_jump  = (i == 1);
            imem_ack   = (i == 2);
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        take_jump = 1'b0; imem_ack = 1'b0;
        n_total++; if (instr !== 32'h0800_0040) $display("FAIL stall_instr: got %h want %h", instr, 32'h0800_0040); else n_pass++;
        n_total++; if (pc !== 32'h8) $display("FAIL stall_pc: got %h want %h", pc, 32'h8); else n_pass++;
        n_total++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) $display("FAIL stall_hs: req %b valid %b want 0 1", imem_req, instr_valid); else n_pass++;
        advance(1'b0, 1'b0);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) $display("FAIL stall_release: req %b addr %h want 1 %h", imem_req, imem_addr, 32'hC); else n_pass++;
    endtask

    task automatic test_branch_jump;
        fetch(32'h0800_0040, seen, addr);
        advance(1'b1, 1'b0);
        n_total++; if (imem_addr !== 32'h100) $display("FAIL jump_addr: got %h want %h", imem_addr, 32'h100); else n_pass++;
        fetch(32'h1000_FFFF, seen, addr);
        n_total++; if (pc_plus4 !== 32'h104) $display("FAIL pc4_100: got %h want %h", pc_plus4, 32'h104); else n_pass++;
        advance(1'b0, 1'b1);
        n_total++; if (imem_addr !== 32'h100) $display("FAIL branch_back: got %h want %h", imem_addr, 32'h100); else n_pass++;
        fetch(32'h0800_0010, seen, addr);
        advance(1'b1, 1'b0);
        n_total++; if (imem_addr !== 32'h40) $display("FAIL jump_40: got %h want %h", imem_addr, 32'h40); else n_pass++;
        fetch(32'h0800_0010, seen, addr);
        advance(1'b1, 1'b1);
        n_total++; if (imem_addr !== 32'h40) $display("FAIL jump_priority: got %h want %h", imem_addr, 32'h40); else n_pass++;
        fetch(32'h1000_FFEE, seen, addr);
        advance(1'b0, 1'b1);
        n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL branch_top: got %h want %h", imem_addr, 32'hFFFF_FFFC); else n_pass++;
        fetch(32'h1000_0003, seen, addr);
        n_total++; if (pc_plus4 !== 32'h0) $display("FAIL pc4_wrap: got %h want %h", pc_plus4, 32'h0); else n_pass++;
        advance(1'b0, 1'b0);
        n_total++; if (imem_addr !== 32'h0) $display("FAIL seq_wrap: got %h want %h", imem_addr, 32'h0); else n_pass++;
        fetch(32'h1000_0003, seen, addr);
        advance(1'b0, 1'b1);
        n_total++; if (imem_addr !== 32'h10) $display("FAIL branch_fwd: got %h want %h", imem_addr, 32'h10); else n_pass++;
    endtask

    task automatic test_reset_mid_req;
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL midreq_reset: pc %h req %b valid %b want 0 0 0", pc, imem_req, instr_valid); else n_pass++;
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        n_total++; if (instr !== 32'h0 || instr_valid !== 1'b0) $display("FAIL late_ack: instr %h valid %b want 0 0", instr, instr_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL restart: req %b addr %h want 1 %h", imem_req, imem_addr, 32'h0); else n_pass++;
    endtask

    task automatic test_timeout;
        fetch(32'h8C01_0004, seen, addr);
        advance(1'b0, 1'b0);
`ifdef FETCH_TIMEOUT_EN
        repeat (15) @(negedge clk);
        n_total++; if (imem_req !== 1'b1 || fetch_error !== 1'b0) $display("FAIL tmo_early: req %b err %b want 1 0", imem_req, fetch_error); else n_pass++;
        @(negedge clk);
        n_total++; if (fetch_error !== 1'b1 || instr_valid !== 1'b1) $display("FAIL tmo_fire: err %b valid %b want 1 1", fetch_error, instr_valid); else n_pass++;
        n_total++; if (instr !== 32'h0 || pc !== 32'h4) $display("FAIL tmo_state: instr %h pc %h want 0 %h", instr, pc, 32'h4); else n_pass++;
        advance(1'b0, 1'b0);
        fetch(32'h8C01_0004, seen, addr);
        n_total++; if (fetch_error !== 1'b1 || pc !== 32'h8) $display("FAIL tmo_sticky: err %b pc %h want 1 %h", fetch_error, pc, 32'h8); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++; if (fetch_error !== 1'b0) $display("FAIL tmo_clear: got %b want 0", fetch_error); else n_pass++;
`else
        repeat (40) @(negedge clk);
        n_total++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) $display("FAIL no_tmo_wait: req %b valid %b want 1 0", imem_req, instr_valid); else n_pass++;
        n_total++; if (fetch_error !== 1'b0 || instr !== 32'h8C01_0004) $display("FAIL no_tmo_state: err %b instr %h want 0 %h", fetch_error, instr, 32'h8C01_0004); else n_pass++;
        fetch(32'h0000_0000, seen, addr);
        n_total++; if (!seen || addr !== 32'h4 || instr_valid !== 1'b1) $display("FAIL no_tmo_ack: seen %b addr %h valid %b", seen, addr, instr_valid); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch_jump();
        test_reset_mid_req();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset; ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 The block SHALL have these memory-side ports:
- imem_addr out 32: fetch address.
- imem_req out 1: fetch request.
- imem_rdata in 32: instruction word.
- imem_ack in 1: rdata valid this cycle.
REQ-003 The block SHALL have these control-side ports:
- stall in 1: hold current instruction.
- take_branch in 1: branch AND zero from datapath.
- take_jump in 1: jump from control decode.
REQ-004 The block SHALL have these outputs:
- instr out 32: instruction register.
- opcode out 6: equals instr[31:26], feeds control decode.
- pc out 32: address of instr.
- pc_plus4 out 32: pc+4.
- instr_valid out 1: instr is fetched and current.
- fetch_error out 1: sticky timeout flag.

Function
REQ-005 The FSM SHALL have three states, IDLE, REQ and VALID; IDLE SHALL advance to REQ on the next clock, unconditionally.
REQ-006 In REQ the block SHALL drive imem_req=1 and imem_addr=pc; on imem_ack=1 it SHALL register instr<=imem_rdata and enter VALID next cycle (minimum 1 cycle in REQ).
REQ-007 Outside REQ the block SHALL drive imem_req=0, and imem_ack SHALL be ignored.
REQ-008 In VALID the block SHALL drive instr_valid=1, and instr, pc and opcode SHALL remain stable.
REQ-009 In VALID with stall=1 the block SHALL hold all state, and take_branch/take_jump SHALL be ignored.
REQ-010 In VALID with stall=0 the block SHALL load the next pc and enter REQ; next pc priority:
- take_jump: jump target.
- else take_branch: branch target.
- else pc_plus4.
REQ-011 Jump target SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-012 Branch target SHALL be pc_plus4 + (sign-extended instr[15:0] << 2), modulo 2^32.
REQ-013 Simultaneous take_jump and take_branch SHALL select the jump target.
REQ-014 pc_plus4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000), and pc[1:0] SHALL always be 2'b00.
REQ-015 take_branch/take_jump SHALL be sampled only in VALID with stall=0.
REQ-016 instr_valid SHALL be 0 in IDLE and REQ (one bubble cycle minimum per instruction).

Reset
REQ-017 Reset SHALL be synchronous and active-high, and SHALL override all other inputs on the same edge.
REQ-018 Reset values SHALL be:
- state=IDLE, pc=0x00000000, instr=0x00000000 (opcode 000000).
- instr_valid=0, imem_req=0, fetch_error=0.
- timeout counter=0.
REQ-019 Reset asserted mid-REQ SHALL abandon the pending fetch; a late imem_ack after reset SHALL be ignored, since the block is in IDLE.

Configuration
REQ-020 Macro FETCH_TIMEOUT_EN SHALL compile in a fetch timeout.
- Defined: a 4-bit counter clears on REQ entry and increments each REQ cycle without ack. After 16 such cycles the block loads instr=0x00000000 (NOP), sets fetch_error=1 (sticky until reset), and enters VALID with pc unchanged.
- Not defined: REQ waits indefinitely, and fetch_error is tied to 0.

Verification
REQ-021 Reset, then ack every first REQ cycle with rdata=0x8C010004 -> instr_valid=1 at cycle 3, opcode=6'b100011, pc=0, then pc=4 on next VALID.
REQ-022 VALID with pc=0x100, instr=0x1000FFFF, take_branch=1 -> next imem_addr=0x100 (0x104 + (-1<<2)).
REQ-023 VALID with pc=0x0000_0040, instr=0x08000010, take_jump=1 and take_branch=1 together -> next imem_addr=0x00000040 (jump wins).
REQ-024 stall=1 held 5 cycles in VALID with take_jump pulsed -> instr/pc unchanged, imem_req=0, jump ignored; release -> pc+4 fetched.
REQ-025 Reset asserted in REQ, imem_ack=1 the next cycle -> instr stays 0, state IDLE, fetch restarts at 0x0.
REQ-026 With FETCH_TIMEOUT_EN defined, no ack for 16 REQ cycles -> fetch_error=1, instr=0, instr_valid=1, pc unchanged; the error stays 1 until reset.
